// File: rtl/avl_st_video_packer_if.sv
// Stream bundle for the video packer: 24-bit pixel input and packed byte output.
interface avl_st_video_packer_if #(
    parameter int unsigned OUT_BYTES = 4
);
    localparam int unsigned EMPTY_W = $clog2(OUT_BYTES);
    localparam int unsigned OUT_W   = 8 * OUT_BYTES;

    logic [23:0]        in_avl_st_data;
    logic               in_avl_st_valid;
    logic               in_avl_st_startofpacket;
    logic               in_avl_st_endofpacket;
    logic               in_avl_st_ready;

    logic [OUT_W-1:0]   out_avl_st_data;
    logic               out_avl_st_valid;
    logic               out_avl_st_startofpacket;
    logic               out_avl_st_endofpacket;
    logic [EMPTY_W-1:0] out_avl_st_empty;
    logic               out_avl_st_ready;

    // Packer view: consumes the pixel stream, produces the byte stream.
    modport slave (
        input  in_avl_st_data, in_avl_st_valid, in_avl_st_startofpacket, in_avl_st_endofpacket,
        output in_avl_st_ready,
        output out_avl_st_data, out_avl_st_valid, out_avl_st_startofpacket,
        output out_avl_st_endofpacket, out_avl_st_empty,
        input  out_avl_st_ready
    );

    // Environment view: drives pixels, sinks packed words.
    modport master (
        output in_avl_st_data, in_avl_st_valid, in_avl_st_startofpacket, in_avl_st_endofpacket,
        input  in_avl_st_ready,
        input  out_avl_st_data, out_avl_st_valid, out_avl_st_startofpacket,
        input  out_avl_st_endofpacket, out_avl_st_empty,
        output out_avl_st_ready
    );
endinterface

// File: rtl/avl_st_video_packer.sv
// Avalon-ST video to little-endian byte-stream packer with show-ahead output FIFO.
module avl_st_video_packer #(
    parameter int unsigned OUT_BYTES  = 4,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [1:0]                  pix_fmt,
    avl_st_video_packer_if.slave        avl,
    output logic [7:0]                  ctrl_pkt_cnt,
    output logic                        err_pulse
);
    localparam int unsigned EMPTY_W = $clog2(OUT_BYTES);
    localparam int unsigned DW      = 8 * OUT_BYTES;
    localparam int unsigned ACC_W   = 8 * (OUT_BYTES + 3);
    localparam int unsigned CNT_W   = $clog2(OUT_BYTES + 3) + 1;
    localparam int unsigned AW      = $clog2(FIFO_DEPTH);
    localparam int unsigned FC_W    = AW + 1;
    localparam int unsigned WORD_W  = DW + 2 + EMPTY_W;

    typedef enum logic [1:0] {S_IDLE, S_VIDEO, S_SKIP, S_FLUSH} state_e;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               first_q, first_d;
    logic               fmt565_q, fmt565_d;
    logic [7:0]         ctrl_q, ctrl_d;
    logic               err_q, err_d;

    logic [WORD_W-1:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [FC_W-1:0]    fcnt_q;

    logic               fifo_full_c, out_valid_c, rd_en_c, wr_en_c;
    logic               in_ready_c, accept_c, decode_hdr_c;
    logic [WORD_W-1:0]  wr_word_c, head_c;
    logic [15:0]        p565_c;
    logic [23:0]        pix_bytes_c;
    logic [CNT_W-1:0]   pix_n_c, sum_cnt_c;
    logic [ACC_W-1:0]   acc_sum_c;

    assign fifo_full_c = (fcnt_q == FC_W'(FIFO_DEPTH));
    assign out_valid_c = (fcnt_q != '0);
    assign rd_en_c     = out_valid_c && avl.out_avl_st_ready;
    assign in_ready_c  = !fifo_full_c && (state_q != S_FLUSH);
    assign accept_c    = avl.in_avl_st_valid && in_ready_c;

    // Pixel to byte lanes (lane 0 first) and accumulator append.
    always_comb begin
        p565_c = {avl.in_avl_st_data[23:19], avl.in_avl_st_data[15:10], avl.in_avl_st_data[7:3]};
        if (fmt565_q) begin
            pix_bytes_c = {8'h00, p565_c[15:8], p565_c[7:0]};
            pix_n_c     = CNT_W'(2);
        end else begin
            pix_bytes_c = {avl.in_avl_st_data[7:0], avl.in_avl_st_data[15:8], avl.in_avl_st_data[23:16]};
            pix_n_c     = CNT_W'(3);
        end
        sum_cnt_c = cnt_q + pix_n_c;
        acc_sum_c = acc_q | (ACC_W'(pix_bytes_c) << {cnt_q, 3'b000});
    end

    // Frame FSM: header decode, packing, flush of the partial last word.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        first_d      = first_q;
        fmt565_d     = fmt565_q;
        ctrl_d       = ctrl_q;
        err_d        = 1'b0;
        wr_en_c      = 1'b0;
        wr_word_c    = '0;
        decode_hdr_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    if (avl.in_avl_st_startofpacket) decode_hdr_c = 1'b1;
                    else                             err_d        = 1'b1;
                end
            end
            S_VIDEO: begin
                if (accept_c) begin
                    if (avl.in_avl_st_startofpacket) begin
                        err_d        = 1'b1;
                        decode_hdr_c = 1'b1;
                    end else begin
                        if (sum_cnt_c >= CNT_W'(OUT_BYTES)) begin
                            wr_en_c   = 1'b1;
                            first_d   = 1'b0;
                            acc_d     = acc_sum_c >> DW;
                            cnt_d     = sum_cnt_c - CNT_W'(OUT_BYTES);
                            wr_word_c = {first_q, avl.in_avl_st_endofpacket && (cnt_d == '0),
                                         {EMPTY_W{1'b0}}, acc_sum_c[DW-1:0]};
                        end else begin
                            acc_d = acc_sum_c;
                            cnt_d = sum_cnt_c;
                        end
                        if (avl.in_avl_st_endofpacket) state_d = (cnt_d == '0) ? S_IDLE : S_FLUSH;
                    end
                end
            end
            S_SKIP: begin
                if (accept_c) begin
                    if (avl.in_avl_st_startofpacket) begin
                        err_d        = 1'b1;
                        decode_hdr_c = 1'b1;
                    end else if (avl.in_avl_st_endofpacket) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_FLUSH: begin
                if (!fifo_full_c) begin
                    wr_en_c   = 1'b1;
                    wr_word_c = {first_q, 1'b1, EMPTY_W'(OUT_BYTES - 32'(cnt_q)), acc_q[DW-1:0]};
                    acc_d     = '0;
                    cnt_d     = '0;
                    first_d   = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Header beat: any residue from an interrupted frame is discarded here.
        if (decode_hdr_c) begin
            acc_d   = '0;
            cnt_d   = '0;
            first_d = 1'b0;
            if (avl.in_avl_st_data[3:0] == 4'h0) begin
                fmt565_d = (pix_fmt == 2'd1);
                first_d  = 1'b1;
                state_d  = avl.in_avl_st_endofpacket ? S_IDLE : S_VIDEO;
            end else begin
                if (avl.in_avl_st_data[3:0] == 4'hF) ctrl_d = ctrl_q + 8'd1;
                state_d = avl.in_avl_st_endofpacket ? S_IDLE : S_SKIP;
            end
        end
    end

    // FSM and accumulator state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            first_q  <= 1'b0;
            fmt565_q <= 1'b0;
            ctrl_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            first_q  <= first_d;
            fmt565_q <= fmt565_d;
            ctrl_q   <= ctrl_d;
            err_q    <= err_d;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fcnt_q   <= '0;
        end else begin
            if (wr_en_c) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_en_c) rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({wr_en_c, rd_en_c})
                2'b10:   fcnt_q <= fcnt_q + FC_W'(1);
                2'b01:   fcnt_q <= fcnt_q - FC_W'(1);
                default: fcnt_q <= fcnt_q;
            endcase
        end
    end

    // FIFO storage; contents are don't-care while unoccupied.
    always_ff @(posedge clk) begin
        if (wr_en_c) mem_q[wr_ptr_q] <= wr_word_c;
    end

    assign head_c                       = mem_q[rd_ptr_q];
    assign avl.in_avl_st_ready          = in_ready_c;
    assign avl.out_avl_st_valid         = out_valid_c;
    assign avl.out_avl_st_data          = out_valid_c ? head_c[DW-1:0] : '0;
    assign avl.out_avl_st_empty         = out_valid_c ? head_c[DW +: EMPTY_W] : '0;
    assign avl.out_avl_st_endofpacket   = out_valid_c && head_c[DW + EMPTY_W];
    assign avl.out_avl_st_startofpacket = out_valid_c && head_c[DW + EMPTY_W + 1];
    assign ctrl_pkt_cnt                 = ctrl_q;
    assign err_pulse                    = err_q;
endmodule

// File: tb/tb_avl_st_video_packer.sv
// Randomised and directed bench for avl_st_video_packer with a frame-level byte model.
`timescale 1ns/1ps
module tb_avl_st_video_packer;
    localparam int unsigned OB    = 4;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned EW    = $clog2(OB);
    localparam int unsigned DW    = 8 * OB;
    localparam int unsigned WW    = DW + 2 + EW;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] pix_fmt;
    logic [7:0] ctrl_pkt_cnt;
    logic       err_pulse;
    logic       out_rdy;

    avl_st_video_packer_if #(.OUT_BYTES(OB)) bus ();

    avl_st_video_packer #(.OUT_BYTES(OB), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pix_fmt      (pix_fmt),
        .avl          (bus),
        .ctrl_pkt_cnt (ctrl_pkt_cnt),
        .err_pulse    (err_pulse)
    );

    always #5 clk = ~clk;
    assign bus.out_avl_st_ready = out_rdy;

    int n_checks, n_pass;
    int rdy_mode, ir_low_cnt, err_cnt, pop_cnt, ctrl_exp, err_exp;
    bit gap_en, prev_stall;
    logic [WW-1:0] prev_word;
    logic [WW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [WW-1:0] mk(input logic s, input logic e, input logic [EW-1:0] em,
                                         input logic [DW-1:0] d);
        return {s, e, em, d};
    endfunction

    // Sink ready: 0 = always, 1 = random, 2 = held off.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_rdy = 1'b1;
            1:       out_rdy = ($urandom_range(0, 3) != 0);
            default: out_rdy = 1'b0;
        endcase
    end

    // Output monitor and scoreboard.
    always @(negedge clk) begin
        logic [WW-1:0] w;
        w = {bus.out_avl_st_startofpacket, bus.out_avl_st_endofpacket,
             bus.out_avl_st_empty, bus.out_avl_st_data};
        if (rst_n) begin
            if (!bus.in_avl_st_ready) ir_low_cnt++;
            if (err_pulse) err_cnt++;
            if (prev_stall) begin
                check("hold_valid", bus.out_avl_st_valid, 1);
                check("hold_stable", w, prev_word);
            end
            prev_stall = bus.out_avl_st_valid && !bus.out_avl_st_ready;
            prev_word  = w;
            if (bus.out_avl_st_valid && bus.out_avl_st_ready) begin
                pop_cnt++;
                check("word_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("out_word", w, exp_q.pop_front());
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Reference: serialise pixels to bytes, cut into words, pad the tail.
    task automatic model_frame(input bit is565, input logic [23:0] px[$], input bit complete);
        logic [7:0] b[$];
        logic [15:0] p;
        int nw;
        foreach (px[i]) begin
            if (is565) begin
                p = {px[i][23:19], px[i][15:10], px[i][7:3]};
                b.push_back(p[7:0]);
                b.push_back(p[15:8]);
            end else begin
                b.push_back(px[i][23:16]);
                b.push_back(px[i][15:8]);
                b.push_back(px[i][7:0]);
            end
        end
        nw = complete ? (b.size() + OB - 1) / OB : b.size() / OB;
        for (int w = 0; w < nw; w++) begin
            logic [DW-1:0] d;
            int nb;
            bit last;
            d  = '0;
            nb = 0;
            for (int k = 0; k < OB; k++) begin
                if (w * OB + k < b.size()) begin
                    d[8*k +: 8] = b[w * OB + k];
                    nb++;
                end
            end
            last = complete && (w == nw - 1);
            exp_q.push_back(mk(w == 0, last, last ? EW'(OB - nb) : EW'(0), d));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [23:0] d, input bit sop, input bit eop);
        bit r;
        int guard;
        r = 1'b0;
        guard = 0;
        bus.in_avl_st_data          = d;
        bus.in_avl_st_valid         = 1'b1;
        bus.in_avl_st_startofpacket = sop;
        bus.in_avl_st_endofpacket   = eop;
        while (!r && guard < 400) begin
            @(negedge clk);
            r = bus.in_avl_st_ready;
            step();
            guard++;
        end
        if (!r) check("beat_accept_timeout", r, 1);
        bus.in_avl_st_valid         = 1'b0;
        bus.in_avl_st_startofpacket = 1'b0;
        bus.in_avl_st_endofpacket   = 1'b0;
        if (gap_en) repeat ($urandom_range(0, 2)) step();
    endtask

    task automatic send_frame(input logic [3:0] nib, input logic [1:0] fmt, input logic [23:0] px[$],
                              input bit complete, input bit use_model);
        logic [19:0] hi;
        hi = 20'($urandom);
        pix_fmt = fmt;
        if (use_model && nib == 4'h0) model_frame(fmt == 2'd1, px, complete);
        if (nib == 4'hF) ctrl_exp++;
        send_beat({hi, nib}, 1'b1, 1'b0);
        foreach (px[i]) send_beat(px[i], 1'b0, complete && (i == px.size() - 1));
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while (guard < 2000) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus.out_avl_st_valid) break;
            guard++;
        end
        check("drain_left", exp_q.size(), 0);
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [23:0] px[$];
        int p0, kind, n;
        bit aborted;
        n_checks = 0; n_pass = 0; rdy_mode = 0; ir_low_cnt = 0; err_cnt = 0; pop_cnt = 0;
        ctrl_exp = 0; err_exp = 0; gap_en = 1'b0; prev_stall = 1'b0; prev_word = '0;
        rst_n = 1'b0; pix_fmt = 2'd0;
        bus.in_avl_st_data = '0; bus.in_avl_st_valid = 1'b0;
        bus.in_avl_st_startofpacket = 1'b0; bus.in_avl_st_endofpacket = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", bus.out_avl_st_valid, 0);
        check("rst_out_data", bus.out_avl_st_data, 0);
        check("rst_out_sop_eop_empty", {bus.out_avl_st_startofpacket, bus.out_avl_st_endofpacket,
                                        bus.out_avl_st_empty}, 0);
        check("rst_ctrl_cnt", ctrl_pkt_cnt, 0);
        check("rst_err", err_pulse, 0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", bus.in_avl_st_ready, 1);
        step();

        // RGB888 exact fit.
        exp_q.push_back(mk(1, 0, 0, 32'h44332211));
        exp_q.push_back(mk(0, 0, 0, 32'h88776655));
        exp_q.push_back(mk(0, 1, 0, 32'hCCBBAA99));
        px = '{24'h112233, 24'h445566, 24'h778899, 24'hAABBCC};
        send_frame(4'h0, 2'd0, px, 1, 0);
        wait_drain();

        // RGB888 with flush; input stalls exactly one cycle.
        ir_low_cnt = 0;
        exp_q.push_back(mk(1, 0, 0, 32'h44332211));
        exp_q.push_back(mk(0, 1, 2, 32'h00006655));
        px = '{24'h112233, 24'h445566};
        send_frame(4'h0, 2'd0, px, 1, 0);
        wait_drain();
        check("flush_ready_low", ir_low_cnt, 1);

        // RGB565 single word.
        exp_q.push_back(mk(1, 1, 0, 32'h07E0F81F));
        px = '{24'hF800F8, 24'h00FC00};
        send_frame(4'h0, 2'd1, px, 1, 0);
        wait_drain();

        // Control packet dropped and counted, then a normal frame.
        px = '{24'h010203, 24'h040506, 24'h070809};
        send_frame(4'hF, 2'd0, px, 1, 0);
        @(negedge clk);
        check("ctrl_cnt_one", ctrl_pkt_cnt, 1);
        step();
        exp_q.push_back(mk(1, 0, 0, 32'h44332211));
        exp_q.push_back(mk(0, 0, 0, 32'h88776655));
        exp_q.push_back(mk(0, 1, 0, 32'hCCBBAA99));
        px = '{24'h112233, 24'h445566, 24'h778899, 24'hAABBCC};
        send_frame(4'h0, 2'd0, px, 1, 0);
        wait_drain();

        // Backpressure: sink held off for 20 cycles during a 12-pixel frame.
        ir_low_cnt = 0;
        p0 = pop_cnt;
        px.delete();
        for (int i = 0; i < 12; i++) px.push_back(24'($urandom));
        fork
            send_frame(4'h0, 2'd0, px, 1, 1);
            begin
                repeat (2) @(posedge clk);
                rdy_mode = 2;
                repeat (20) @(posedge clk);
                rdy_mode = 0;
            end
        join
        wait_drain();
        check("bp_word_count", pop_cnt - p0, 9);
        check("bp_in_ready_dropped", ir_low_cnt > 0, 1);

        // SOP mid-frame after one pixel.
        err_cnt = 0;
        px = '{24'h112233};
        send_frame(4'h0, 2'd0, px, 0, 0);
        exp_q.push_back(mk(1, 0, 0, 32'h77665544));
        exp_q.push_back(mk(0, 1, 2, 32'h00009988));
        px = '{24'h445566, 24'h778899};
        send_frame(4'h0, 2'd0, px, 1, 0);
        wait_drain();
        check("sop_mid_err_pulses", err_cnt, 1);

        // Randomised traffic with gaps, sink stalls, aborts and stray beats.
        err_cnt = 0;
        err_exp = 0;
        gap_en = 1'b1;
        rdy_mode = 1;
        aborted = 1'b0;
        for (int f = 0; f < 40; f++) begin
            kind = $urandom_range(0, 9);
            if (aborted && kind == 8) kind = 0;
            if (aborted) err_exp++;
            aborted = 1'b0;
            n = $urandom_range(1, 16);
            px.delete();
            for (int i = 0; i < n; i++) px.push_back(24'($urandom));
            case (kind)
                5: begin send_frame(4'h0, 2'($urandom_range(0, 3)), px, 0, 1); aborted = 1'b1; end
                6: send_frame(4'hF, 2'd0, px, 1, 1);
                7: send_frame(4'h3, 2'd0, px, 1, 1);
                8: begin send_beat(24'($urandom), 1'b0, 1'($urandom)); err_exp++; end
                default: send_frame(4'h0, 2'($urandom_range(0, 3)), px, 1, 1);
            endcase
        end
        if (aborted) begin
            err_exp++;
            px = '{24'($urandom)};
            send_frame(4'h0, 2'd1, px, 1, 1);
        end
        wait_drain();
        check("rand_err_count", err_cnt, err_exp);
        check("rand_ctrl_cnt", ctrl_pkt_cnt, 8'(ctrl_exp));

        // Reset in the middle of a frame with a word waiting in the FIFO.
        gap_en = 1'b0;
        rdy_mode = 2;
        px = '{24'($urandom), 24'($urandom)};
        send_frame(4'h0, 2'd0, px, 0, 1);
        step();
        @(negedge clk);
        check("pre_rst_valid", bus.out_avl_st_valid, 1);
        check("pre_rst_ctrl", ctrl_pkt_cnt, 8'(ctrl_exp));
        step();
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", bus.out_avl_st_valid, 0);
        check("mid_rst_ctrl", ctrl_pkt_cnt, 0);
        check("mid_rst_in_ready", bus.in_avl_st_ready, 1);
        exp_q.delete();
        ctrl_exp = 0;
        step();
        rst_n = 1'b1;
        rdy_mode = 0;
        step();
        exp_q.push_back(mk(1, 0, 0, 32'h44332211));
        exp_q.push_back(mk(0, 1, 2, 32'h00006655));
        px = '{24'h112233, 24'h445566};
        send_frame(4'h0, 2'd0, px, 1, 0);
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
